// File: rtl/exe_muldiv_unit.sv
// rtl/exe_muldiv_unit.sv - EXE-stage multiply/divide unit owning the architectural HI/LO registers
module exe_muldiv_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MulDivOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        EXE_Flush,
    output logic        MulDiv_Stall,
    output logic        MulDiv_Busy,
    output logic [31:0] EXE_HI,
    output logic [31:0] EXE_LO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        stall;

    logic        op_signed;
    logic        op_start;
    logic        op_is_mul;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [32:0] rem_shift;
    logic [32:0] rem_trial;
    logic        q_bit;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    assign op_signed = (EXE_MulDivOp == OP_MULT) || (EXE_MulDivOp == OP_DIV);
    assign op_is_mul = (EXE_MulDivOp == OP_MULT) || (EXE_MulDivOp == OP_MULTU);
    assign op_start  = op_is_mul || (EXE_MulDivOp == OP_DIV) || (EXE_MulDivOp == OP_DIVU);

    // Magnitude of 0x80000000 wraps to itself and is then treated as unsigned.
    assign mag_a = (op_signed && EXE_BusA[31]) ? (32'd0 - EXE_BusA) : EXE_BusA;
    assign mag_b = (op_signed && EXE_BusB[31]) ? (32'd0 - EXE_BusB) : EXE_BusB;

    // Operands are held stable in a_q/b_q for the whole MUL phase, so the
    // product path has MUL_CYCLES cycles to settle before it is committed.
    assign prod     = {32'd0, a_q} * {32'd0, b_q};
    assign prod_fix = negq_q ? (64'd0 - prod) : prod;

    // a_q doubles as the dividend/quotient shift register during DIV.
    assign rem_shift = {rem_q, a_q[31]};
    assign rem_trial = rem_shift - {1'b0, b_q};
    assign q_bit     = ~rem_trial[32];
    assign rem_next  = q_bit ? rem_trial[31:0] : rem_shift[31:0];
    assign quo_next  = {a_q[30:0], q_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        stall   = 1'b0;

        if (EXE_Flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_start) begin
                        stall  = 1'b1;
                        a_d    = mag_a;
                        b_d    = mag_b;
                        rem_d  = 32'd0;
                        negq_d = op_signed && (EXE_BusA[31] ^ EXE_BusB[31]);
                        negr_d = op_signed && EXE_BusA[31];
                        if (op_is_mul) begin
                            state_d = S_MUL;
                            cnt_d   = 6'(MUL_CYCLES);
                        end else begin
                            state_d = S_DIV;
                            cnt_d   = 6'(DIV_CYCLES);
                        end
                    end else if (EXE_MulDivOp == OP_MTHI) begin
                        hi_d = EXE_BusA;
                    end else if (EXE_MulDivOp == OP_MTLO) begin
                        lo_d = EXE_BusA;
                    end
                end
                S_MUL: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_d    = prod_fix[63:32];
                        lo_d    = prod_fix[31:0];
                        state_d = S_DONE;
                    end
                end
                S_DIV: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 6'd1;
                    a_d   = quo_next;
                    rem_d = rem_next;
                    if (cnt_q == 6'd1) begin
                        lo_d    = negq_q ? (32'd0 - quo_next) : quo_next;
                        hi_d    = negr_q ? (32'd0 - rem_next) : rem_next;
                        state_d = S_DONE;
                    end
                end
                default: begin
                    // DONE: the instruction advances; its op is still on the input and must not restart.
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign MulDiv_Stall = stall;
    assign MulDiv_Busy  = (state_q == S_MUL) || (state_q == S_DIV);
    assign EXE_HI       = hi_q;
    assign EXE_LO       = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb/tb_exe_muldiv_unit.sv - directed scoreboard bench for exe_muldiv_unit
module tb_exe_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] bus_a = 32'd0;
    logic [31:0] bus_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    exe_muldiv_unit #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_MulDivOp (op),
        .EXE_BusA     (bus_a),
        .EXE_BusB     (bus_b),
        .EXE_Flush    (flush),
        .MulDiv_Stall (stall),
        .MulDiv_Busy  (busy),
        .EXE_HI       (hi),
        .EXE_LO       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        op    = o;
        bus_a = v;
        step();
        op    = 3'd0;
    endtask

    // Holds the op while stalled and through DONE, as the frozen ID/EXE register would.
    task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] ehi, input logic [31:0] elo, input int estall,
                          input string tag);
        int n;
        logic [63:0] e;
        sb_q.push_back({ehi, elo});
        op    = o;
        bus_a = xa;
        bus_b = xb;
        n     = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(estall));
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        e = sb_q.pop_front();
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
        step();
        op = 3'd0;
    endtask

    task automatic flush_at(input int k, input string tag);
        op    = 3'd4;
        bus_a = 32'h0000_1234;
        bus_b = 32'h0000_0005;
        repeat (k - 2) step();
        @(negedge clk);
        chk({tag, "_stall_before"}, {31'd0, stall}, 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk({tag, "_stall_flush"}, {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        op    = 3'd0;
        @(negedge clk);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, 32'hAAAA_0000);
        chk({tag, "_lo"}, lo, 32'h0000_5555);
        step();
    endtask

    initial begin
        repeat (2) step();
        @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b1;
        step();

        mt(3'd5, 32'h1111_1111);
        mt(3'd6, 32'h2222_2222);
        chk("mt_hi", hi, 32'h1111_1111);
        chk("mt_lo", lo, 32'h2222_2222);

        op    = 3'd4;
        bus_a = 32'd100;
        bus_b = 32'd7;
        repeat (9) step();
        @(negedge clk);
        chk("middiv_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        op = 3'd0;
        @(posedge clk);
        @(negedge clk);
        chk("middiv_rst_hi", hi, 32'd0);
        chk("middiv_rst_lo", lo, 32'd0);
        chk("middiv_rst_stall", {31'd0, stall}, 32'd0);
        chk("middiv_rst_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b1;
        step();

        run_op(3'd4, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33, "divu_100_7");
        run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, "mult_neg");
        run_op(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 3, "multu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_ovf");
        run_op(3'd4, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 33, "divu_by0");
        run_op(3'd3, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0001, 33, "div_neg_by0");
        run_op(3'd3, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFFF, 33, "div_pos_by0");

        mt(3'd5, 32'hAAAA_0000);
        mt(3'd6, 32'h0000_5555);
        chk("pre_hi", hi, 32'hAAAA_0000);
        chk("pre_lo", lo, 32'h0000_5555);
        flush_at(20, "flush_c20");
        flush_at(33, "flush_last");

        op    = 3'd6;
        bus_a = 32'h0000_0042;
        step();
        chk("b2b_mtlo", lo, 32'h0000_0042);
        run_op(3'd2, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 3, "b2b_multu");
        @(negedge clk);
        chk("b2b_no_restall", {31'd0, stall}, 32'd0);
        chk("b2b_no_busy", {31'd0, busy}, 32'd0);
        step();
        @(negedge clk);
        chk("b2b_lo_hold", lo, 32'h0000_000C);
        chk("b2b_hi_hold", hi, 32'h0000_0000);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
